dmem_arbiter: RTL and testbench

Two-requester arbiter and access sequencer for the single-cycle core's word-organised data memory. It shares one memory port between the core load/store path (port 0) and the program-loader/debug port (port 1) using round-robin arbitration. It converts byte-addressed, sized requests into word accesses, with read-modify-write for sb/sh. Load data comes back aligned and sign- or zero-extended, with rsp_err on misaligned, out-of-range or reserved-size requests.

---
 rtl/dmem_pkg.sv | 39 +++
 rtl/dmem_lane_fmt.sv | 50 +++++
 rtl/dmem_arbiter.sv | 157 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: size codes, FSM states, latched request.
// Also the request legality check, used on the latched request.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WRITE,
    RESP
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic        owner;
  } req_t;

  // i_hi_nz: some address bit above the memory's byte range is set
  function automatic logic req_bad(input logic [31:0] i_addr, input logic [1:0] i_size,
                                   input logic i_hi_nz);
    logic w_bad;
    w_bad = i_hi_nz;
    case (i_size)
      SZ_H:    if (i_addr[0]) w_bad = 1'b1;
      SZ_W:    if (i_addr[1:0] != 2'b00) w_bad = 1'b1;
      SZ_B:    ;
      default: w_bad = 1'b1;
    endcase
    return w_bad;
  endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte/half lane handling: load extract + sign/zero extend, and store merge into a read word.
// Purely combinational; no state, no handshake.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_size,
  input  logic        i_uns,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte   = i_rdata[7:0];
    w_half   = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_load   = i_rdata;
    o_merged = i_wdata;
    case (i_off)
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    case (i_size)
      SZ_B: begin
        o_load   = {{24{~i_uns & w_byte[7]}}, w_byte};
        o_merged = i_rdata;
        case (i_off)
          2'd1:    o_merged[15:8]  = i_wdata[7:0];
          2'd2:    o_merged[23:16] = i_wdata[7:0];
          2'd3:    o_merged[31:24] = i_wdata[7:0];
          default: o_merged[7:0]   = i_wdata[7:0];
        endcase
      end
      SZ_H: begin
        o_load   = {{16{~i_uns & w_half[15]}}, w_half};
        o_merged = i_rdata;
        if (i_off[1]) o_merged[31:16] = i_wdata[15:0];
        else          o_merged[15:0]  = i_wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer sharing one word memory between core (p0) and loader (p1).
// Response 2 cycles after gnt (3 for sb/sh); requesters hold req until gnt, no gnt outside IDLE.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic [31:0]   p0_addr,
  input  logic          p0_we,
  input  logic [1:0]    p0_size,
  input  logic          p0_uns,
  input  logic [31:0]   p0_wdata,
  output logic          p0_gnt,
  output logic          p0_rsp_valid,
  output logic [31:0]   p0_rsp_rdata,
  output logic          p0_rsp_err,
  input  logic          p1_req,
  input  logic [31:0]   p1_addr,
  input  logic          p1_we,
  input  logic [1:0]    p1_size,
  input  logic          p1_uns,
  input  logic [31:0]   p1_wdata,
  output logic          p1_gnt,
  output logic          p1_rsp_valid,
  output logic [31:0]   p1_rsp_rdata,
  output logic          p1_rsp_err,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  state_t      r_state;
  state_t      w_state_nxt;
  req_t        r_req;
  req_t        w_win;
  logic        r_last;
  logic [31:0] r_data;
  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_err;
  logic [31:0] w_load;
  logic [31:0] w_merged;
  logic [31:0] w_rsp_rdata;

  assign w_gnt0 = (r_state == IDLE) && p0_req && (!p1_req || r_last);
  assign w_gnt1 = (r_state == IDLE) && p1_req && !w_gnt0;

  always_comb begin
    if (w_gnt1) w_win = '{addr: p1_addr, we: p1_we, size: p1_size, uns: p1_uns,
                          wdata: p1_wdata, owner: 1'b1};
    else        w_win = '{addr: p0_addr, we: p0_we, size: p0_size, uns: p0_uns,
                          wdata: p0_wdata, owner: 1'b0};
  end

  assign w_err = req_bad(r_req.addr, r_req.size, (r_req.addr >> (AW + 2)) != 32'd0);

  dmem_lane_fmt u_lane_fmt (
    .i_rdata  (mem_rdata),
    .i_off    (r_req.addr[1:0]),
    .i_size   (r_req.size),
    .i_uns    (r_req.uns),
    .i_wdata  (r_req.wdata),
    .o_load   (w_load),
    .o_merged (w_merged)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    p0_gnt       = 1'b0;
    p1_gnt       = 1'b0;
    p0_rsp_valid = 1'b0;
    p1_rsp_valid = 1'b0;
    p0_rsp_rdata = 32'd0;
    p1_rsp_rdata = 32'd0;
    p0_rsp_err   = 1'b0;
    p1_rsp_err   = 1'b0;
    mem_addr     = '0;
    mem_we       = 1'b0;
    mem_wdata    = 32'd0;
    w_rsp_rdata  = (r_req.we || w_err) ? 32'd0 : r_data;
    case (r_state)
      IDLE: begin
        p0_gnt = w_gnt0;
        p1_gnt = w_gnt1;
        if (w_gnt0 || w_gnt1) w_state_nxt = ACCESS;
      end
      ACCESS: begin
        mem_addr    = r_req.addr[AW+1:2];
        w_state_nxt = RESP;
        if (!w_err && r_req.we) begin
          if (r_req.size == SZ_W) begin
            mem_we    = 1'b1;
            mem_wdata = w_merged;
          end else begin
            w_state_nxt = WRITE;
          end
        end
      end
      WRITE: begin
        mem_addr    = r_req.addr[AW+1:2];
        mem_we      = 1'b1;
        mem_wdata   = r_data;
        w_state_nxt = RESP;
      end
      RESP: begin
        w_state_nxt = IDLE;
        if (r_req.owner) begin
          p1_rsp_valid = 1'b1;
          p1_rsp_rdata = w_rsp_rdata;
          p1_rsp_err   = w_err;
        end else begin
          p0_rsp_valid = 1'b1;
          p0_rsp_rdata = w_rsp_rdata;
          p0_rsp_err   = w_err;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    // An aborting reset must not commit the pending write or hand out anything.
    if (rst) begin
      p0_gnt       = 1'b0;
      p1_gnt       = 1'b0;
      p0_rsp_valid = 1'b0;
      p1_rsp_valid = 1'b0;
      p0_rsp_rdata = 32'd0;
      p1_rsp_rdata = 32'd0;
      p0_rsp_err   = 1'b0;
      p1_rsp_err   = 1'b0;
      mem_we       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req  <= '0;
      r_last <= 1'b1;
      r_data <= 32'd0;
    end else begin
      if (w_gnt0 || w_gnt1) begin
        r_req  <= w_win;
        r_last <= w_gnt1;
      end
      // Holds the extended load result, or the merged word for the following WRITE.
      if (r_state == ACCESS) r_data <= r_req.we ? w_merged : w_load;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a transaction-level reference model checked every cycle.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p0_req = 1'b0, p1_req = 1'b0;
  logic [31:0] p0_addr = '0, p1_addr = '0, p0_wdata = '0, p1_wdata = '0;
  logic        p0_we = 1'b0, p1_we = 1'b0, p0_uns = 1'b0, p1_uns = 1'b0;
  logic [1:0]  p0_size = '0, p1_size = '0;
  logic        p0_gnt, p1_gnt, p0_rsp_valid, p1_rsp_valid, p0_rsp_err, p1_rsp_err;
  logic [31:0] p0_rsp_rdata, p1_rsp_rdata;
  logic [7:0]  mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata, mem_rdata;

  logic [31:0] mem [256] = '{default: 32'd0};

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(8)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_we(p0_we), .p0_size(p0_size), .p0_uns(p0_uns),
    .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rsp_valid(p0_rsp_valid),
    .p0_rsp_rdata(p0_rsp_rdata), .p0_rsp_err(p0_rsp_err),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_we(p1_we), .p1_size(p1_size), .p1_uns(p1_uns),
    .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rsp_valid(p1_rsp_valid),
    .p1_rsp_rdata(p1_rsp_rdata), .p1_rsp_err(p1_rsp_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [31:0] mm [256] = '{default: 32'd0};
  int          cyc = 0, m_idle_at = 0, m_last = 1, e_we_cyc = -1, e_rsp_cyc = -1, e_port = 0;
  int          mw;
  logic [31:0] ma, mwd, mword, e_rdata, e_we_dat;
  logic [1:0]  msz;
  logic        mwe, muns, e_err, eg0, eg1, ev;
  logic [7:0]  e_we_addr;
  int          rsp_cnt = 0, we_cnt = 0;

  function automatic logic m_bad(input logic [31:0] a, input logic [1:0] sz);
    return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0) || (a >= 32'd1024);
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [31:0] a,
                                         input logic [1:0] sz, input logic uns);
    logic [31:0] v;
    if (sz == 2'd2) return w;
    if (sz == 2'd0) begin
      v = (w >> (8 * (a % 4))) & 32'hFF;
      if (!uns && v >= 32'h80) v = v - 32'h100;
    end else begin
      v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v - 32'h10000;
    end
    return v;
  endfunction

  function automatic logic [31:0] m_merge(input logic [31:0] w, input logic [31:0] a,
                                          input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] mask, sh;
    if (sz == 2'd2) return d;
    sh   = (sz == 2'd0) ? 8 * (a % 4) : 16 * ((a / 2) % 2);
    mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF);
    return (w & ~(mask << sh)) | ((d & mask) << sh);
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (mem_we) we_cnt++;
    if (p0_rsp_valid || p1_rsp_valid) rsp_cnt++;
    if (rst) begin
      chk("rst_gnt", 32'({p1_gnt, p0_gnt}), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_rsp_valid", 32'({p1_rsp_valid, p0_rsp_valid}), 32'd0);
      m_idle_at = cyc + 1;
      m_last    = 1;
      e_we_cyc  = -1;
      e_rsp_cyc = -1;
    end else begin
      eg0 = 1'b0;
      eg1 = 1'b0;
      if (cyc >= m_idle_at && (p0_req || p1_req)) begin
        if (p0_req && p1_req) mw = (m_last == 1) ? 0 : 1;
        else                  mw = p0_req ? 0 : 1;
        ma   = mw ? p1_addr : p0_addr;
        mwe  = mw ? p1_we : p0_we;
        msz  = mw ? p1_size : p0_size;
        muns = mw ? p1_uns : p0_uns;
        mwd  = mw ? p1_wdata : p0_wdata;
        if (mw == 0) eg0 = 1'b1; else eg1 = 1'b1;
        m_last  = mw;
        e_port  = mw;
        mword   = mm[ma[9:2]];
        e_err   = 1'b0;
        e_rdata = 32'd0;
        if (m_bad(ma, msz)) begin
          e_err     = 1'b1;
          e_rsp_cyc = cyc + 2;
        end else if (!mwe) begin
          e_rdata   = m_load(mword, ma, msz, muns);
          e_rsp_cyc = cyc + 2;
        end else begin
          e_we_addr = ma[9:2];
          e_we_dat  = m_merge(mword, ma, msz, mwd);
          e_we_cyc  = (msz == 2'd2) ? cyc + 1 : cyc + 2;
          e_rsp_cyc = e_we_cyc + 1;
        end
        m_idle_at = e_rsp_cyc + 1;
      end
      chk("gnt", 32'({p1_gnt, p0_gnt}), 32'({eg1, eg0}));
      chk("mem_we", 32'(mem_we), 32'(cyc == e_we_cyc));
      if (cyc == e_we_cyc) begin
        chk("mem_addr", 32'(mem_addr), 32'(e_we_addr));
        chk("mem_wdata", mem_wdata, e_we_dat);
        mm[e_we_addr] = e_we_dat;
      end
      ev = (cyc == e_rsp_cyc);
      chk("rsp_valid", 32'({p1_rsp_valid, p0_rsp_valid}),
          32'({ev && e_port == 1, ev && e_port == 0}));
      chk("p0_rdata", p0_rsp_rdata, (ev && e_port == 0) ? e_rdata : 32'd0);
      chk("p1_rdata", p1_rsp_rdata, (ev && e_port == 1) ? e_rdata : 32'd0);
      chk("rsp_err", 32'({p1_rsp_err, p0_rsp_err}),
          32'({ev && e_port == 1 && e_err, ev && e_port == 0 && e_err}));
    end
  end

  // ---------------- directed stimulus ----------------
  int gq[$];

  task automatic do_req(input int port, input logic [31:0] addr, input logic we,
                        input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
    time tg;
    bit  got;
    rdata = 32'hxxxxxxxx;
    err   = 1'bx;
    lat   = -1;
    @(posedge clk); #1;
    if (port == 0) begin
      p0_addr = addr; p0_we = we; p0_size = size; p0_uns = uns; p0_wdata = wdata; p0_req = 1'b1;
    end else begin
      p1_addr = addr; p1_we = we; p1_size = size; p1_uns = uns; p1_wdata = wdata; p1_req = 1'b1;
    end
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (port == 0 ? p0_gnt : p1_gnt) got = 1'b1;
    end
    chk("gnt_seen", 32'(got), 32'd1);
    if (got) gq.push_back(port);
    tg = $time;
    @(posedge clk); #1;
    if (port == 0) p0_req = 1'b0; else p1_req = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      if (port == 0 ? p0_rsp_valid : p1_rsp_valid) begin
        got   = 1'b1;
        rdata = (port == 0) ? p0_rsp_rdata : p1_rsp_rdata;
        err   = (port == 0) ? p0_rsp_err : p1_rsp_err;
        lat   = int'(($time - tg) / 10);
      end
    end
    chk("rsp_seen", 32'(got), 32'd1);
  endtask

  logic [31:0] rd, rd1;
  logic        er, er1;
  int          lat, lat1, snap;
  bit          got;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", p0_rsp_rdata | p1_rsp_rdata, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    do_req(0, 32'h10, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF, rd, er, lat);
    chk("sw_lat", 32'(lat), 32'd2);
    chk("sw_err", 32'(er), 32'd0);
    chk("sw_mem", mem[4], 32'hDEADBEEF);
    do_req(0, 32'h10, 1'b0, 2'd2, 1'b0, 32'd0, rd, er, lat);
    chk("lw_data", rd, 32'hDEADBEEF);
    chk("lw_lat", 32'(lat), 32'd2);

    do_req(0, 32'h12, 1'b1, 2'd0, 1'b0, 32'h55, rd, er, lat);
    chk("sb_lat", 32'(lat), 32'd3);
    chk("sb_mem", mem[4], 32'hDE55BEEF);
    do_req(0, 32'h13, 1'b0, 2'd0, 1'b0, 32'd0, rd, er, lat);
    chk("lb_data", rd, 32'hFFFFFFDE);
    do_req(0, 32'h13, 1'b0, 2'd0, 1'b1, 32'd0, rd, er, lat);
    chk("lbu_data", rd, 32'h000000DE);
    do_req(0, 32'h10, 1'b0, 2'd1, 1'b0, 32'd0, rd, er, lat);
    chk("lh_data", rd, 32'hFFFFBEEF);

    snap = we_cnt;
    do_req(0, 32'h11, 1'b0, 2'd2, 1'b0, 32'd0, rd, er, lat);
    chk("lw_mis_err", 32'(er), 32'd1);
    chk("lw_mis_rdata", rd, 32'd0);
    do_req(0, 32'h13, 1'b0, 2'd1, 1'b0, 32'd0, rd, er, lat);
    chk("lh_mis_err", 32'(er), 32'd1);
    do_req(0, 32'h10, 1'b0, 2'd3, 1'b0, 32'd0, rd, er, lat);
    chk("size3_err", 32'(er), 32'd1);
    chk("size3_rdata", rd, 32'd0);
    do_req(0, 32'h400, 1'b1, 2'd2, 1'b0, 32'h12345678, rd, er, lat);
    chk("oor_err", 32'(er), 32'd1);
    chk("oor_lat", 32'(lat), 32'd2);
    chk("err_no_we", 32'(we_cnt - snap), 32'd0);
    chk("err_mem0", mem[0], 32'd0);

    do_req(1, 32'h22, 1'b1, 2'd1, 1'b0, 32'hABCD, rd, er, lat);
    chk("sh_lat", 32'(lat), 32'd3);
    chk("sh_mem", mem[8], 32'hABCD0000);
    do_req(0, 32'h22, 1'b0, 2'd1, 1'b1, 32'd0, rd, er, lat);
    chk("lhu_data", rd, 32'h0000ABCD);

    // reset in the WRITE cycle of a byte store
    @(posedge clk); #1;
    p0_addr = 32'h30; p0_we = 1'b1; p0_size = 2'd0; p0_uns = 1'b0; p0_wdata = 32'h77; p0_req = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      if (p0_gnt) got = 1'b1;
    end
    chk("rst_test_gnt", 32'(got), 32'd1);
    @(posedge clk); #1 p0_req = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    snap = we_cnt;
    lat  = rsp_cnt;
    repeat (5) @(negedge clk);
    chk("rst_abort_no_we", 32'(we_cnt - snap), 32'd0);
    chk("rst_abort_no_rsp", 32'(rsp_cnt - lat), 32'd0);

    // both ports requesting back to back
    gq.delete();
    fork
      begin
        do_req(0, 32'h10, 1'b0, 2'd2, 1'b0, 32'd0, rd, er, lat);
        chk("rr_p0a", rd, 32'hDE55BEEF);
        do_req(0, 32'h22, 1'b0, 2'd1, 1'b0, 32'd0, rd, er, lat);
        chk("rr_p0b", rd, 32'hFFFFABCD);
      end
      begin
        do_req(1, 32'h20, 1'b0, 2'd2, 1'b0, 32'd0, rd1, er1, lat1);
        chk("rr_p1a", rd1, 32'hABCD0000);
        do_req(1, 32'h13, 1'b0, 2'd0, 1'b1, 32'd0, rd1, er1, lat1);
        chk("rr_p1b", rd1, 32'h000000DE);
      end
    join
    chk("rr_count", 32'(gq.size()), 32'd4);
    if (gq.size() == 4) begin
      chk("rr_g0", 32'(gq[0]), 32'd0);
      chk("rr_g1", 32'(gq[1]), 32'd1);
      chk("rr_g2", 32'(gq[2]), 32'd0);
      chk("rr_g3", 32'(gq[3]), 32'd1);
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
